dmem_responder: RTL

//  Data-memory responder for the pipelined CPU's MEM stage. Replaces the

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Fixed-latency request/acknowledge word memory for the CPU MEM stage.
// One transaction in flight; busy_o stalls the pipeline until the ack cycle ends.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W:0] AddrLimit = (ADDR_W + 1)'(DEPTH) << 2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              enter_resp;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              op_err;
  logic [IdxW-1:0]   op_idx;
  logic              mem_we;

  // With LATENCY=1 the RESP entry happens on the accept edge, so the live
  // request fields are used instead of the not-yet-latched copies.
  always_comb begin
    op_we    = (state_q == StIdle) ? we_i    : we_q;
    op_addr  = (state_q == StIdle) ? addr_i  : addr_q;
    op_wdata = (state_q == StIdle) ? wdata_i : wdata_q;
    op_err   = (op_addr[1:0] != 2'b00) || ({1'b0, op_addr} >= AddrLimit);
    op_idx   = op_addr[IdxW+1:2];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          if (LATENCY == 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_we  = enter_resp & op_we & ~op_err;
    ack_d   = enter_resp;
    err_d   = enter_resp & op_err;
    busy_d  = (state_d != StIdle);
    rdata_d = rdata_q;
    if (enter_resp) begin
      rdata_d = (op_we || op_err) ? '0 : mem_q[op_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; a reset on the commit edge drops the store.
  always_ff @(posedge clk_i) begin
    if (rst_i && mem_we) begin
      mem_q[op_idx] <= op_wdata;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign busy_o  = busy_q;
  assign rdata_o = rdata_q;

endmodule
